// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 command bytes, sequencer FSM states and LED bit positions.
package ps2_pkg;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_RESET    = 8'hFF;
    localparam int LED_SCROLL = 0;
    localparam int LED_NUM    = 1;
    localparam int LED_CAPS   = 2;
    typedef enum logic [2:0] {IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG} state_t;
endpackage

// File: rtl/ps2_command_sequencer_if.sv
// ps2_command_sequencer_if: host command request handshake and completion pulses.
interface ps2_command_sequencer_if;
    logic       req_valid;
    logic [7:0] req_cmd;
    logic       req_has_arg;
    logic [7:0] req_arg;
    logic       req_ready;
    logic       done;
    logic       err;
    modport master (output req_valid, req_cmd, req_has_arg, req_arg, input req_ready, done, err);
    modport slave  (input req_valid, req_cmd, req_has_arg, req_arg, output req_ready, done, err);
endinterface

// File: rtl/ps2_command_sequencer.sv
// ps2_command_sequencer: serializes LED updates and host commands to the PS/2 controller,
// handling ACK/RESEND/timeout and hiding consumed ACK/RESEND bytes from the scancode path.
module ps2_command_sequencer
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] scan_data,
    output logic       scan_en,
    input  logic       caps_toggle,
    input  logic       num_toggle,
    input  logic       scroll_toggle,
    output logic [2:0] leds,
    ps2_command_sequencer_if.slave host
);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t        r_state;
    logic [7:0]    r_cmd, r_arg, r_the_command, r_scan_data;
    logic          r_has_arg, r_is_led, r_send, r_done, r_err, r_req_ready, r_scan_en, r_led_pending;
    logic [RW-1:0] r_retry;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_leds, w_toggle;
    logic          w_waiting, w_ack, w_resend, w_led_req, w_led_accept;

    always_comb begin
        w_toggle = '0;
        w_toggle[LED_CAPS]   = caps_toggle;
        w_toggle[LED_NUM]    = num_toggle;
        w_toggle[LED_SCROLL] = scroll_toggle;
    end

    assign w_waiting    = r_state == WAIT_CMD || r_state == WAIT_ARG;
    assign w_ack        = received_data_en && received_data == PS2_ACK;
    assign w_resend     = received_data_en && received_data == PS2_RESEND;
    // A toggle in the arbitration cycle already counts as a pending LED update
    assign w_led_req    = r_led_pending || (|w_toggle);
    assign w_led_accept = r_state == IDLE && w_led_req;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_leds        <= '0;
            r_led_pending <= 1'b0;
            r_scan_data   <= '0;
            r_scan_en     <= 1'b0;
        end else begin
            r_leds        <= r_leds ^ w_toggle;
            r_led_pending <= w_led_req && !w_led_accept;
            r_scan_data   <= received_data;
            r_scan_en     <= received_data_en && !(w_waiting && (w_ack || w_resend));
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_arg         <= '0;
            r_has_arg     <= 1'b0;
            r_is_led      <= 1'b0;
            r_the_command <= '0;
            r_send        <= 1'b0;
            r_retry       <= '0;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_req_ready   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_retry <= '0;
                    if (w_led_req) begin
                        r_cmd     <= PS2_SET_LEDS;
                        r_has_arg <= 1'b1;
                        r_is_led  <= 1'b1;
                        r_state   <= SEND_CMD;
                    end else if (host.req_valid) begin
                        r_cmd       <= host.req_cmd;
                        r_has_arg   <= host.req_has_arg;
                        r_arg       <= host.req_arg;
                        r_is_led    <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= SEND_CMD;
                    end
                end
                SEND_CMD, SEND_ARG: begin
                    r_the_command <= r_state == SEND_CMD ? r_cmd : r_arg;
                    if (r_send && (command_was_sent || error_communication_timed_out)) begin
                        r_send  <= 1'b0;
                        r_cnt   <= '0;
                        r_err   <= error_communication_timed_out;
                        r_state <= error_communication_timed_out ? IDLE :
                                   (r_state == SEND_CMD ? WAIT_CMD : WAIT_ARG);
                    end else begin
                        r_send <= 1'b1;
                    end
                end
                WAIT_CMD, WAIT_ARG: begin
                    if (w_ack) begin
                        r_retry <= '0;
                        if (r_state == WAIT_CMD && r_has_arg) begin
                            r_state <= SEND_ARG;
                            if (r_is_led) r_arg <= {5'b0, r_leds};
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_resend) begin
                        if (r_retry < RETRY_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= r_state == WAIT_CMD ? SEND_CMD : SEND_ARG;
                        end else begin
                            r_state <= IDLE;
                            r_err   <= 1'b1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign the_command    = r_the_command;
    assign send_command   = r_send;
    assign scan_data      = r_scan_data;
    assign scan_en        = r_scan_en;
    assign leds           = r_leds;
    assign host.req_ready = r_req_ready;
    assign host.done      = r_done;
    assign host.err       = r_err;
endmodule
